keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart to the board's multiplexed seven-segment display path: the display block drives anodes and segments out; this block drives keypad columns and reads rows back in.
- Scans a 4x4 matrix keypad (Pmod KYPD on a Nexys 4 header) with one active-low column at a time.
- Synchronizes and debounces the row returns, then emits a 4-bit hex key code with a one-cycle valid strobe.
- Sits beside the CPU driver and lets switches or buttons be replaced by keypad entry, e.g. register, PC or immediate input.

Parameters:
CLK_DIV, 100000, Clk_100MHz cycles per column dwell (1 kHz column rate); minimum 4
DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; minimum 1

Ports:
Clk_100MHz  input  1  system clock; all state on the rising edge
Reset  input  1  asynchronous, active-high reset
Row  input  4  keypad row returns; active-low, externally pulled up
Col  output  4  keypad column drives; active-low, exactly one bit low at a time
KeyCode  output  4  hex value of the last accepted key
KeyValid  output  1  one-cycle pulse when a new key is accepted
KeyHeld  output  1  level, high while the accepted key is considered pressed

Behaviour:
- Reset (asynchronous, active-high):
  - Col=4'b1110, KeyCode=0, KeyValid=0, KeyHeld=0.
  - Tick counter=0, column index=0, debounce count=0, FSM in IDLE.
  - Row synchronizer flops go to 4'b1111.
  - Reset mid-scan or mid-debounce discards all partial state. No KeyValid is produced by reset or by its release.
- Row input is passed through a 2-flop synchronizer before any use.
- Tick counter:
  - Counts 0..CLK_DIV-1, then wraps.
  - Tick = terminal count, a one-cycle pulse.
- On each tick:
  - The synchronized Row is sampled for the current column.
  - The column index then advances 0->1->2->3->0.
  - Col = ~(4'b0001 << index).
- Key map (row r, column c; code = hex value):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Scan result, evaluated on the tick that samples column 3:
  - NONE: no zero row bits in any of the 4 columns.
  - SINGLE(code): exactly one zero row bit across the 4 columns.
  - MULTI: more than one zero row bit.
  - The per-scan accumulator clears after evaluation.
- FSM (transitions only at scan evaluation):
  - IDLE: SINGLE(k) -> latch candidate k, count=1, go to DEBOUNCE. If DEBOUNCE_SCANS=1, accept immediately (see below).
  - DEBOUNCE:
    - SINGLE(candidate) -> count+1.
    - Different SINGLE -> restart with the new candidate, count=1.
    - NONE or MULTI -> IDLE, count=0.
    - On count reaching DEBOUNCE_SCANS, accept: KeyCode<=candidate, KeyValid=1 for exactly the next cycle, KeyHeld<=1, go to PRESSED.
  - PRESSED:
    - NONE -> count+1.
    - SINGLE or MULTI (any key) -> count=0. No rollover; a second key is ignored until full release.
    - On count reaching DEBOUNCE_SCANS -> KeyHeld<=0, go to IDLE.
    - KeyCode holds its last value after release.
- Latency: KeyValid rises 1 cycle after the evaluation tick of the DEBOUNCE_SCANS-th matching scan. Worst case from a stable press is (DEBOUNCE_SCANS+1)*4*CLK_DIV+3 cycles.
- KeyValid is never high on two consecutive cycles and never fires twice for one press.
- Arithmetic:
  - Tick counter width is $clog2(CLK_DIV).
  - Debounce count width is $clog2(DEBOUNCE_SCANS+1) and saturates at DEBOUNCE_SCANS.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - Adds parameters REPEAT_DELAY (default 500 scans) and REPEAT_RATE (default 100 scans).
  - While in PRESSED and every scan is SINGLE(KeyCode), a repeat counter counts scans.
  - At REPEAT_DELAY, then every REPEAT_RATE scans after that, KeyValid pulses again with the same KeyCode.
  - Any non-matching scan resets the repeat counter.
- Undefined: no repeat logic or parameters exist; exactly one KeyValid per press.

Decomposition:
- Shared package keypad_pkg holds:
  - state enum IDLE/DEBOUNCE/PRESSED;
  - scan-result enum NONE/SINGLE/MULTI;
  - the 16-entry key map constant indexed {row,col}.
- One sub-module, keypad_tick_gen: parameterized by CLK_DIV; outputs the tick pulse and the 2-bit column index; asynchronous reset.

Test Plan:
- Bench uses CLK_DIV=4, DEBOUNCE_SCANS=3 and a keypad model that pulls Row[r] low when Col[c] is low and key (r,c) is pressed.
- Idle, no key for 20 scans -> Col cycles 1110,1101,1011,0111; KeyValid never asserts; KeyHeld=0.
- Press r1c2 stable -> one KeyValid pulse with KeyCode=4'h6 about 3 scans later; KeyHeld=1; release -> KeyHeld=0 after 3 NONE scans; KeyCode stays 6.
- Bounce: r3c0 toggling every 5 cycles for 3 scans, then stable -> exactly one KeyValid, KeyCode=4'h0, only after 3 stable scans.
- Hold r0c3 ('A'), then add r2c1 ('8') -> no new KeyValid; release both, press r2c1 alone -> KeyValid, KeyCode=4'h8.
- Assert Reset in DEBOUNCE with key r1c0 held -> outputs return to reset values immediately; after deassert, a full 3-scan debounce runs before KeyValid with KeyCode=4'h4.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2 -> hold '5' gives pulses at accept, accept+5 scans, then every 2 scans.

Source files
------------

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 matrix keypad scanner.
//   state_e      : debounce FSM states (IDLE / DEBOUNCE / PRESSED)
//   scan_e       : result of one full four-column scan (NONE / SINGLE / MULTI)
//   KEY_MAP      : 16 hex codes packed as nibbles, indexed {row, col}
//   key_code()   : KEY_MAP lookup
//   count_zeros(): number of active (low) row returns in one column sample
//   first_zero() : index of the lowest active row in one column sample
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } scan_e;

    // Nibble {row, col} holds the printed legend of that key:
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_code(input logic [3:0] idx);
        return KEY_MAP[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [2:0] count_zeros(input logic [3:0] bits);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~bits[i]};
        end
        return n;
    endfunction

    function automatic logic [1:0] first_zero(input logic [3:0] bits);
        logic [1:0] idx;
        idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!bits[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// -----------------------------------------------------------------------------
// keypad_tick_gen
// Column dwell timer: counts 0..CLK_DIV-1 and pulses o_tick on the terminal
// count; the column index advances 0->1->2->3->0 on every tick.
//   i_clk       : system clock
//   i_rst       : asynchronous active-high reset
//   o_tick      : one-cycle pulse at the end of each column dwell
//   o_col_idx   : column currently being driven
// -----------------------------------------------------------------------------
module keypad_tick_gen #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_tick,
    output logic [1:0] o_col_idx
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_col_idx;
    logic             w_tick;

    assign w_tick    = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign o_tick    = w_tick;
    assign o_col_idx = r_col_idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_col_idx <= '0;
        end else if (w_tick) begin
            r_cnt     <= '0;
            r_col_idx <= r_col_idx + 2'd1;
        end else begin
            r_cnt     <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 matrix keypad one active-low column at a time, synchronises and
// debounces the row returns and reports accepted keys as a 4-bit hex code.
//   Clk_100MHz : system clock, rising edge
//   Reset      : asynchronous active-high reset
//   Row        : row returns, active-low (pulled up off-chip)
//   Col        : column drives, active-low, one low at a time
//   KeyCode    : hex value of the last accepted key (kept after release)
//   KeyValid   : one-cycle pulse per accepted key
//   KeyHeld    : high while the accepted key is considered pressed
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat (REPEAT_DELAY scans
// to the first repeat, then one every REPEAT_RATE scans while held alone).
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_RATE    = 100
`endif
) (
    input  logic       Clk_100MHz,
    input  logic       Reset,
    input  logic [3:0] Row,
    output logic [3:0] Col,
    output logic [3:0] KeyCode,
    output logic       KeyValid,
    output logic       KeyHeld
);

    localparam int unsigned    DB_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_SCANS);
    localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RATE  = REP_W'(REPEAT_RATE);
    localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);

    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] r_rep_target;
`endif

    logic            w_tick;
    logic [1:0]      w_col_idx;
    logic [3:0]      r_row_meta;
    logic [3:0]      r_row_sync;
    logic [1:0]      r_acc_hits;   // saturates at 2: anything above one is MULTI
    logic [3:0]      r_acc_code;
    logic [2:0]      w_row_zeros;
    logic [2:0]      w_hits_sum;
    logic [1:0]      w_hits;
    logic [3:0]      w_code;
    logic            w_eval;
    scan_e           w_result;
    state_e          r_state;
    logic [3:0]      r_cand;
    logic [DB_W-1:0] r_db_cnt;
    logic [3:0]      r_key_code;
    logic            r_key_valid;
    logic            r_key_held;

    keypad_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .i_clk     (Clk_100MHz),
        .i_rst     (Reset),
        .o_tick    (w_tick),
        .o_col_idx (w_col_idx)
    );

    assign Col      = ~(4'b0001 << w_col_idx);
    assign KeyCode  = r_key_code;
    assign KeyValid = r_key_valid;
    assign KeyHeld  = r_key_held;

    always_ff @(posedge Clk_100MHz or posedge Reset) begin
        if (Reset) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= Row;
            r_row_sync <= r_row_meta;
        end
    end

    // Fold the current column sample into the running scan tally. The code is
    // only meaningful when the total hit count ends up at exactly one.
    always_comb begin
        w_row_zeros = count_zeros(r_row_sync);
        w_hits_sum  = {1'b0, r_acc_hits} + w_row_zeros;
        w_hits      = (w_hits_sum >= 3'd2) ? 2'd2 : w_hits_sum[1:0];
        w_code      = r_acc_code;
        if ((r_acc_hits == 2'd0) && (w_row_zeros != 3'd0)) begin
            w_code = key_code({first_zero(r_row_sync), w_col_idx});
        end
        w_eval   = w_tick && (w_col_idx == 2'd3);
        w_result = NONE;
        if (w_hits == 2'd1) begin
            w_result = SINGLE;
        end else if (w_hits == 2'd2) begin
            w_result = MULTI;
        end
    end

    always_ff @(posedge Clk_100MHz or posedge Reset) begin
        if (Reset) begin
            r_acc_hits <= '0;
            r_acc_code <= '0;
        end else if (w_eval) begin
            r_acc_hits <= '0;
            r_acc_code <= '0;
        end else if (w_tick) begin
            r_acc_hits <= w_hits;
            r_acc_code <= w_code;
        end
    end

    always_ff @(posedge Clk_100MHz or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_cand      <= '0;
            r_db_cnt    <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt    <= '0;
            r_rep_target <= REP_DELAY;
`endif
        end else begin
            r_key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            if (r_state != PRESSED) begin
                r_rep_cnt    <= '0;
                r_rep_target <= REP_DELAY;
            end
`endif
            if (w_eval) begin
                unique case (r_state)
                    IDLE: begin
                        if (w_result == SINGLE) begin
                            r_cand <= w_code;
                            if (DB_MAX == DB_ONE) begin
                                r_key_code  <= w_code;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_db_cnt    <= '0;
                                r_state     <= PRESSED;
                            end else begin
                                r_db_cnt <= DB_ONE;
                                r_state  <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if ((w_result == SINGLE) && (w_code == r_cand)) begin
                            if (r_db_cnt == DB_MAX - DB_ONE) begin
                                r_key_code  <= r_cand;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_db_cnt    <= '0;
                                r_state     <= PRESSED;
                            end else begin
                                r_db_cnt <= r_db_cnt + DB_ONE;
                            end
                        end else if (w_result == SINGLE) begin
                            r_cand   <= w_code;
                            r_db_cnt <= DB_ONE;
                        end else begin
                            r_db_cnt <= '0;
                            r_state  <= IDLE;
                        end
                    end
                    PRESSED: begin
                        // Any key activity restarts the release count: no rollover.
                        if (w_result == NONE) begin
                            if (r_db_cnt == DB_MAX - DB_ONE) begin
                                r_key_held <= 1'b0;
                                r_db_cnt   <= '0;
                                r_state    <= IDLE;
                            end else begin
                                r_db_cnt <= r_db_cnt + DB_ONE;
                            end
                        end else begin
                            r_db_cnt <= '0;
                        end
`ifdef KEYPAD_REPEAT_EN
                        if ((w_result == SINGLE) && (w_code == r_key_code)) begin
                            if (r_rep_cnt == r_rep_target - REP_ONE) begin
                                r_key_valid  <= 1'b1;
                                r_rep_cnt    <= '0;
                                r_rep_target <= REP_RATE;
                            end else begin
                                r_rep_cnt <= r_rep_cnt + REP_ONE;
                            end
                        end else begin
                            r_rep_cnt    <= '0;
                            r_rep_target <= REP_DELAY;
                        end
`endif
                    end
                    default: begin
                        r_db_cnt <= '0;
                        r_state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
